// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// ACT_CODE is the activation pattern also used by the sequence detector bench.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int FRAME_W_DEF    = 10;
  localparam int GAP_CYCLES_DEF = 2;

  localparam logic [9:0] ACT_CODE = 10'b1011011101;

endpackage

// File: rtl/seq_tx_if.sv
// Handshake and serial-output bundle for seq_tx.
// master drives start/frame; slave (the transmitter) drives the rest.
interface seq_tx_if #(
  parameter int FRAME_W = seq_tx_pkg::FRAME_W_DEF
);
  logic               start;
  logic [FRAME_W-1:0] frame;
  logic               ready;
  logic               txd;
  logic               tx_valid;
  logic               done;

  modport master (
    output start, frame,
    input  ready, txd, tx_valid, done
  );

  modport slave (
    input  start, frame,
    output ready, txd, tx_valid, done
  );
endinterface

// File: rtl/seq_tx_shreg.sv
// Parallel-load, left-shift register; MSB is the serial output.
// Synchronous clear on r. Load has priority over shift.
module seq_tx_shreg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         r,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] sh_reg;
  logic [W-1:0] sh_next;

  // Bit 0 takes a zero when shifting; upper bits take their lower neighbour.
  assign sh_next[0] = load ? din[0] : (shift ? 1'b0 : sh_reg[0]);

  genvar gi;
  generate
    for (gi = 1; gi < W; gi++) begin : g_bit
      assign sh_next[gi] = load ? din[gi] : (shift ? sh_reg[gi-1] : sh_reg[gi]);
    end
  endgenerate

  // Shift register state update with synchronous clear.
  always_ff @(posedge clk) begin
    if (r) sh_reg <= '0;
    else   sh_reg <= sh_next;
  end

  assign sout = sh_reg[W-1];

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends a FRAME_W-bit code word MSB first,
// then forces GAP_CYCLES idle cycles before accepting the next word.
// Optional build macro SEQ_TX_PARITY_EN appends an even-parity bit.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int   FRAME_W    = FRAME_W_DEF,
  parameter int   GAP_CYCLES = GAP_CYCLES_DEF,
  parameter logic IDLE_LVL   = 1'b0
) (
  input  logic clk,
  input  logic r,
  seq_tx_if.slave bus
);

  localparam int CW = $clog2(FRAME_W + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_W - 1);
  localparam logic [GW-1:0] GAP_LAST_V = GW'(GAP_LAST);
  // With no gap the line returns straight to IDLE after the frame.
  localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [GW-1:0] gcnt_reg, gcnt_next;
  logic          txd_reg, txd_next;
  logic          valid_reg, valid_next;
  logic          done_reg, done_next;
  logic          ready_reg, ready_next;
  logic          sh_load, sh_shift, sh_msb;
`ifdef SEQ_TX_PARITY_EN
  logic          par_reg, par_next;
`endif

  // The register holds the bits still to come: bit FRAME_W-1 goes straight
  // to txd at acceptance, so its MSB is always the next txd value.
  seq_tx_shreg #(.W(FRAME_W)) u_shreg (
    .clk   (clk),
    .r     (r),
    .load  (sh_load),
    .shift (sh_shift),
    .din   ({bus.frame[FRAME_W-2:0], 1'b0}),
    .sout  (sh_msb)
  );

  // Next-state and next-output decode; outputs are computed one cycle ahead.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gcnt_next  = gcnt_reg;
    txd_next   = IDLE_LVL;
    valid_next = 1'b0;
    done_next  = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          sh_load    = 1'b1;
          cnt_next   = '0;
          state_next = SEND;
          txd_next   = bus.frame[FRAME_W-1];
          valid_next = 1'b1;
`ifdef SEQ_TX_PARITY_EN
          par_next   = ^bus.frame;
`endif
        end
      end
      SEND: begin
        sh_shift = 1'b1;
        if (cnt_reg == FRAME_LAST) begin
`ifdef SEQ_TX_PARITY_EN
          state_next = PAR;
          txd_next   = par_reg;
          valid_next = 1'b1;
`else
          state_next = AFTER_FRAME;
          done_next  = 1'b1;
          gcnt_next  = '0;
`endif
        end else begin
          cnt_next   = cnt_reg + CW'(1);
          txd_next   = sh_msb;
          valid_next = 1'b1;
        end
      end
      PAR: begin
        state_next = AFTER_FRAME;
        done_next  = 1'b1;
        gcnt_next  = '0;
      end
      GAP: begin
        if (gcnt_reg == GAP_LAST_V) state_next = IDLE;
        else                        gcnt_next  = gcnt_reg + GW'(1);
      end
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == IDLE);
  end

  // State, counters and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk) begin
    if (r) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      gcnt_reg  <= '0;
      txd_reg   <= IDLE_LVL;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gcnt_reg  <= gcnt_next;
      txd_reg   <= txd_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      ready_reg <= ready_next;
`ifdef SEQ_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  assign bus.ready    = ready_reg;
  assign bus.txd      = txd_reg;
  assign bus.tx_valid = valid_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: directed steps, with expected serial bits
// queued at acceptance and popped whenever tx_valid is seen.
module tb_seq_tx;
  import seq_tx_pkg::*;

  localparam int FW  = 10;
  localparam int GAP = 2;
`ifdef SEQ_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = FW + PB;

  logic clk = 1'b0;
  logic r;

  seq_tx_if #(.FRAME_W(FW)) bus ();

  seq_tx #(.FRAME_W(FW), .GAP_CYCLES(GAP), .IDLE_LVL(1'b0)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock; sample 1 time unit after the edge and run the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (bus.tx_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("extra_bit", {31'd0, bus.tx_valid}, 32'd0);
        else                   chk("txd", {31'd0, bus.txd}, {31'd0, exp_q.pop_front()});
      end else begin
        chk("idle_txd", {31'd0, bus.txd}, 32'd0);
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  endtask

  task automatic push_frame(input logic [FW-1:0] f);
    for (int i = FW - 1; i >= 0; i--) exp_q.push_back(f[i]);
`ifdef SEQ_TX_PARITY_EN
    exp_q.push_back(^f);
`endif
  endtask

  // Drive start for one accepting edge; afterwards the bench is in cycle N+1.
  task automatic send(input logic [FW-1:0] f, input bit hold);
    push_frame(f);
    bus.frame = f;
    bus.start = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
    $display("tb: frame %b accepted, cycle N+1 bit0 txd=%0b", f, bus.txd);
  endtask

  // Called in cycle N+1; walks the frame and gap, optionally pulsing a busy start.
  task automatic expect_frame(input int pulse_at);
    for (int k = 1; k <= FL + GAP; k++) begin
      chk("tx_valid", {31'd0, bus.tx_valid}, {31'd0, (k <= FL)});
      chk("done",     {31'd0, bus.done},     {31'd0, (k == FL + 1)});
      chk("ready",    {31'd0, bus.ready},    32'd0);
      if (k == pulse_at) begin
        bus.start = 1'b1;
        bus.frame = '1;
      end
      step();
      if (k == pulse_at) bus.start = 1'b0;
    end
    chk("ready_back", {31'd0, bus.ready},    32'd1);
    chk("done_end",   {31'd0, bus.done},     32'd0);
    chk("valid_end",  {31'd0, bus.tx_valid}, 32'd0);
    $display("tb: frame complete, ready=%0b queue=%0d", bus.ready, exp_q.size());
  endtask

  initial begin
    r         = 1'b1;
    bus.start = 1'b0;
    bus.frame = '0;

    // Reset held two cycles.
    step();
    step();
    r = 1'b0;
    mon_en = 1'b1;
    chk("rst_ready", {31'd0, bus.ready},    32'd1);
    chk("rst_txd",   {31'd0, bus.txd},      32'd0);
    chk("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_done",  {31'd0, bus.done},     32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ready", {31'd0, bus.ready},    32'd1);
      chk("idle_valid", {31'd0, bus.tx_valid}, 32'd0);
    end
    $display("tb: reset state checked");

    // Basic frame with the activation code.
    send(ACT_CODE, 1'b0);
    expect_frame(0);

    // Busy: start with all-ones pulsed in cycle N+4 must be ignored.
    send(ACT_CODE, 1'b0);
    expect_frame(4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("busy_no_frame", {31'd0, bus.tx_valid}, 32'd0);
    end
    $display("tb: busy start ignored");

    // Abort: reset at the edge that ends bit 4.
    done_cnt = 0;
    send(ACT_CODE, 1'b0);
    for (int i = 0; i < 4; i++) step();
    exp_q.delete();
    r = 1'b1;
    step();
    r = 1'b0;
    chk("abort_txd",   {31'd0, bus.txd},      32'd0);
    chk("abort_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("abort_ready", {31'd0, bus.ready},    32'd1);
    chk("abort_done",  {31'd0, bus.done},     32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_quiet", {31'd0, bus.done}, 32'd0);
    end
    chk("abort_done_cnt", done_cnt, 32'd0);
    $display("tb: abort checked");
    send(10'b1100101001, 1'b0);
    expect_frame(0);

    // Reset and start together: reset wins, nothing sent.
    r = 1'b1;
    bus.start = 1'b1;
    bus.frame = ACT_CODE;
    step();
    r = 1'b0;
    bus.start = 1'b0;
    chk("rs_ready", {31'd0, bus.ready},    32'd1);
    chk("rs_valid", {31'd0, bus.tx_valid}, 32'd0);
    step();
    chk("rs_no_frame", {31'd0, bus.tx_valid}, 32'd0);
    $display("tb: simultaneous reset/start checked");

    // Back-to-back with start held high: two frames, two done pulses.
    done_cnt = 0;
    send(10'b1000000001, 1'b1);
    expect_frame(0);
    send(10'b1000000001, 1'b0);
    expect_frame(0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b_stop", {31'd0, bus.tx_valid}, 32'd0);
    end
    chk("b2b_done_cnt", done_cnt, 32'd2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("tb: back-to-back checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
